seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for an N-digit common-anode 7-segment display. It sequences one shared hex-to-segment decoder across all digits and drives one anode at a time, with dead-time blanking between digits to prevent ghosting. New values are loaded through a ready/strobe handshake and take effect only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between the status/debug logic and the board display pins.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_hex_decode.sv | 32 +++
 rtl/seg7_scan_ctrl.sv | 169 ++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
// Optional leading-zero blanking: SEG7_LEADING_ZERO_BLANK_EN.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic int digit_cycles(
    input int clk_hz,
    input int refresh_hz
  );
    return clk_hz / refresh_hz;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to active-low segments, [6]=A .. [0]=G.
// Shared by all digits of seg7_scan_ctrl.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_Nibble,
  output logic [6:0] o_Segments
);

  always_comb begin
    o_Segments = SEG_OFF;
    unique case (i_Nibble)
      4'h0: o_Segments = 7'h01;
      4'h1: o_Segments = 7'h4F;
      4'h2: o_Segments = 7'h12;
      4'h3: o_Segments = 7'h06;
      4'h4: o_Segments = 7'h4C;
      4'h5: o_Segments = 7'h24;
      4'h6: o_Segments = 7'h20;
      4'h7: o_Segments = 7'h0F;
      4'h8: o_Segments = 7'h00;
      4'h9: o_Segments = 7'h04;
      4'hA: o_Segments = 7'h08;
      4'hB: o_Segments = 7'h60;
      4'hC: o_Segments = 7'h31;
      4'hD: o_Segments = 7'h42;
      4'hE: o_Segments = 7'h30;
      4'hF: o_Segments = 7'h38;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// N-digit common-anode scan controller with dead-time and frame-aligned loads.
// Optional leading-zero blanking: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_HZ       = 25_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Enable,
  input  logic [4*NUM_DIGITS-1:0] i_Value,
  input  logic [NUM_DIGITS-1:0]   i_Dp,
  input  logic                    i_Load,
  output logic                    o_Load_Ready,
  output logic [NUM_DIGITS-1:0]   o_Anode,
  output logic [6:0]              o_Segments,
  output logic                    o_Dp,
  output logic                    o_Frame_Done
);

  localparam int DC = digit_cycles(CLK_HZ, REFRESH_HZ);
  localparam int CW = (DC > 1) ? $clog2(DC) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_LAST = CW'(DC - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DC) begin : g_bad_blank
    $error("BLANK_CYCLES must be in 1..DIGIT_CYCLES-1");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("NUM_DIGITS must be in 1..8");
  end

  scan_state_t           r_State;
  scan_state_t           w_State_Next;
  logic [CW-1:0]         r_Cnt;
  logic [CW-1:0]         w_Cnt_Next;
  logic [IW-1:0]         r_Idx;
  logic [IW-1:0]         w_Idx_Next;
  logic [VW-1:0]         r_Disp_Val;
  logic [VW-1:0]         r_Pend_Val;
  logic [VW-1:0]         w_Disp_Val_Next;
  logic [NUM_DIGITS-1:0] r_Disp_Dp;
  logic [NUM_DIGITS-1:0] r_Pend_Dp;
  logic [NUM_DIGITS-1:0] w_Disp_Dp_Next;
  logic [NUM_DIGITS-1:0] w_Lz_Blank;
  logic                  r_Pend_Valid;
  logic [6:0]            r_Seg;
  logic                  r_Dp;
  logic [6:0]            w_Dec_Seg;
  logic [3:0]            w_Nibble;
  logic                  w_Slot_End;
  logic                  w_Wrap;
  logic                  w_Enter_Blank;
  logic                  w_Xfer;
  logic                  w_Accept;

  assign w_Slot_End    = (r_State == DRIVE) && (r_Cnt == CNT_LAST);
  assign w_Wrap        = w_Slot_End && (r_Idx == IDX_LAST);
  assign w_Enter_Blank = i_Enable && ((r_State == IDLE) || w_Slot_End);
  assign w_Xfer        = r_Pend_Valid && (w_Wrap || (r_State == IDLE));
  assign w_Accept      = i_Load && !r_Pend_Valid;

  // Segments for the next slot are decoded from the post-transfer value
  assign w_Disp_Val_Next = w_Xfer ? r_Pend_Val : r_Disp_Val;
  assign w_Disp_Dp_Next  = w_Xfer ? r_Pend_Dp : r_Disp_Dp;
  assign w_Nibble        = w_Disp_Val_Next[{w_Idx_Next, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .i_Nibble   (w_Nibble),
    .o_Segments (w_Dec_Seg)
  );

  always_comb begin
    w_Lz_Blank = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    for (int k = 1; k < NUM_DIGITS; k++) begin
      w_Lz_Blank[k] = ((w_Disp_Val_Next >> (4 * k)) == '0);
    end
`endif
  end

  always_comb begin
    w_Idx_Next = r_Idx;
    if (!i_Enable || r_State == IDLE) begin
      w_Idx_Next = '0;
    end else if (w_Slot_End) begin
      w_Idx_Next = (r_Idx == IDX_LAST) ? '0 : r_Idx + 1'b1;
    end
  end

  assign w_Cnt_Next =
    (!i_Enable || r_State == IDLE || r_Cnt == CNT_LAST)
    ? '0 : r_Cnt + 1'b1;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State <= IDLE;
      r_Cnt   <= '0;
      r_Idx   <= '0;
    end else begin
      r_State <= w_State_Next;
      r_Cnt   <= w_Cnt_Next;
      r_Idx   <= w_Idx_Next;
    end
  end

  always_comb begin
    w_State_Next = r_State;
    unique case (r_State)
      IDLE:  if (i_Enable) w_State_Next = BLANK;
      BLANK: begin
        if (!i_Enable) w_State_Next = IDLE;
        else if (r_Cnt == BLK_LAST) w_State_Next = DRIVE;
      end
      DRIVE: begin
        if (!i_Enable) w_State_Next = IDLE;
        else if (r_Cnt == CNT_LAST) w_State_Next = BLANK;
      end
      default: w_State_Next = IDLE;
    endcase
  end

  always_comb begin
    o_Anode      = '1;
    o_Frame_Done = w_Wrap;
    if (r_State == DRIVE) o_Anode[r_Idx] = 1'b0;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Disp_Val   <= '0;
      r_Disp_Dp    <= '0;
      r_Pend_Val   <= '0;
      r_Pend_Dp    <= '0;
      r_Pend_Valid <= 1'b0;
      r_Seg        <= SEG_OFF;
      r_Dp         <= 1'b1;
    end else begin
      if (w_Accept) begin
        r_Pend_Val <= i_Value;
        r_Pend_Dp  <= i_Dp;
      end
      if (w_Xfer) begin
        r_Disp_Val <= r_Pend_Val;
        r_Disp_Dp  <= r_Pend_Dp;
      end
      if (w_Accept) r_Pend_Valid <= 1'b1;
      else if (w_Xfer) r_Pend_Valid <= 1'b0;
      if (!i_Enable) begin
        r_Seg <= SEG_OFF;
        r_Dp  <= 1'b1;
      end else if (w_Enter_Blank) begin
        r_Seg <= w_Lz_Blank[w_Idx_Next] ? SEG_OFF : w_Dec_Seg;
        r_Dp  <= w_Lz_Blank[w_Idx_Next] | ~w_Disp_Dp_Next[w_Idx_Next];
      end
    end
  end

  assign o_Segments   = r_Seg;
  assign o_Dp         = r_Dp;
  assign o_Load_Ready = ~r_Pend_Valid;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: 4 digits, 10-cycle slots, 2-cycle blank.
// Leading-zero expectations follow SEG7_LEADING_ZERO_BLANK_EN.
module tb_seg7_scan_ctrl;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_Rst;
  logic        i_Enable;
  logic [15:0] i_Value;
  logic [3:0]  i_Dp;
  logic        i_Load;
  logic        o_Load_Ready;
  logic [3:0]  o_Anode;
  logic [6:0]  o_Segments;
  logic        o_Dp;
  logic        o_Frame_Done;

  int checks = 0;
  int errors = 0;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (4),
    .CLK_HZ       (1000),
    .REFRESH_HZ   (100),
    .BLANK_CYCLES (2)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (i_Rst),
    .i_Enable     (i_Enable),
    .i_Value      (i_Value),
    .i_Dp         (i_Dp),
    .i_Load       (i_Load),
    .o_Load_Ready (o_Load_Ready),
    .o_Anode      (o_Anode),
    .o_Segments   (o_Segments),
    .o_Dp         (o_Dp),
    .o_Frame_Done (o_Frame_Done)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_anode"}, o_Anode, 4'hF);
    chk({tag, "_seg"}, o_Segments, 7'h7F);
    chk({tag, "_dp"}, o_Dp, 1'b1);
    chk({tag, "_fd"}, o_Frame_Done, 1'b0);
  endtask

  // One digit slot; optional load at sample ldj, then an ignored reload
  task automatic slot(
    input int          k,
    input logic [6:0]  seg,
    input logic        dp,
    input logic        rdy,
    input int          ncyc,
    input int          ldj,
    input logic [15:0] ldv
  );
    logic [3:0] an;
    logic       fd;
    logic       r;
    string      t;
    for (int j = 0; j < ncyc; j++) begin
      @(negedge clk);
      t  = $sformatf("d%0d_j%0d", k, j);
      an = 4'hF;
      if (j >= 2) an[k] = 1'b0;
      fd = (k == 3) && (j == 9);
      r  = (ldj >= 0 && j > ldj) ? 1'b0 : rdy;
      chk({t, "_anode"}, o_Anode, an);
      chk({t, "_seg"}, o_Segments, seg);
      chk({t, "_dp"}, o_Dp, dp);
      chk({t, "_fd"}, o_Frame_Done, fd);
      chk({t, "_rdy"}, o_Load_Ready, r);
      i_Load = 1'b0;
      if (ldj >= 0 && j == ldj) begin
        i_Value = ldv;
        i_Load  = 1'b1;
      end
      if (ldj >= 0 && j == ldj + 1) begin
        i_Value = 16'hFFFF;
        i_Load  = 1'b1;
      end
    end
    i_Load = 1'b0;
  endtask

  task automatic load_idle(input logic [15:0] v, input logic [3:0] d);
    i_Enable = 1'b0;
    @(negedge clk);
    i_Value = v;
    i_Dp    = d;
    i_Load  = 1'b1;
    @(negedge clk);
    i_Load = 1'b0;
    chk("ld_rdy_low", o_Load_Ready, 1'b0);
    @(negedge clk);
    chk("ld_rdy_high", o_Load_Ready, 1'b1);
    chk_dark("ld_idle");
    i_Enable = 1'b1;
  endtask

  initial begin
    i_Rst    = 1'b1;
    i_Enable = 1'b0;
    i_Value  = '0;
    i_Dp     = '0;
    i_Load   = 1'b0;
    repeat (3) @(negedge clk);
    chk_dark("rst");
    chk("rst_rdy", o_Load_Ready, 1'b1);
    i_Rst = 1'b0;

    // Basic scan of 12AB, dp on digit 2
    load_idle(16'h12AB, 4'b0100);
    slot(0, 7'h60, 1'b1, 1'b1, 10, -1, '0);
    slot(1, 7'h08, 1'b1, 1'b1, 10, -1, '0);
    slot(2, 7'h12, 1'b0, 1'b1, 10, -1, '0);
    slot(3, 7'h4F, 1'b1, 1'b1, 10, -1, '0);

    // Mid-frame load lands only at the wrap
    slot(0, 7'h60, 1'b1, 1'b1, 10, -1, '0);
    slot(1, 7'h08, 1'b1, 1'b1, 10, 4, 16'h0003);
    slot(2, 7'h12, 1'b0, 1'b0, 10, -1, '0);
    slot(3, 7'h4F, 1'b1, 1'b0, 10, -1, '0);
    slot(0, 7'h06, 1'b1, 1'b1, 10, -1, '0);
    slot(1, LZB ? 7'h7F : 7'h01, 1'b1, 1'b1, 10, -1, '0);

    // Disable mid-DRIVE of digit 2, then restart
    slot(2, LZB ? 7'h7F : 7'h01, LZB, 1'b1, 5, -1, '0);
    i_Enable = 1'b0;
    @(negedge clk);
    chk_dark("dis1");
    @(negedge clk);
    chk_dark("dis2");
    i_Enable = 1'b1;
    slot(0, 7'h06, 1'b1, 1'b1, 10, -1, '0);
    slot(1, LZB ? 7'h7F : 7'h01, 1'b1, 1'b1, 10, -1, '0);
    slot(2, LZB ? 7'h7F : 7'h01, LZB, 1'b1, 10, -1, '0);

    // Reset during digit 3 DRIVE with a load pending
    slot(3, LZB ? 7'h7F : 7'h01, 1'b1, 1'b1, 7, 3, 16'h4567);
    i_Rst = 1'b1;
    @(negedge clk);
    chk_dark("mrst");
    chk("mrst_rdy", o_Load_Ready, 1'b1);
    i_Rst = 1'b0;
    slot(0, 7'h01, 1'b1, 1'b1, 10, -1, '0);
    slot(1, LZB ? 7'h7F : 7'h01, 1'b1, 1'b1, 10, -1, '0);

    // Leading-zero patterns, all decimal points requested
    load_idle(16'h0050, 4'hF);
    slot(0, 7'h01, 1'b0, 1'b1, 10, -1, '0);
    slot(1, 7'h24, 1'b0, 1'b1, 10, -1, '0);
    slot(2, LZB ? 7'h7F : 7'h01, LZB, 1'b1, 10, -1, '0);
    slot(3, LZB ? 7'h7F : 7'h01, LZB, 1'b1, 10, -1, '0);
    load_idle(16'h0000, 4'hF);
    slot(0, 7'h01, 1'b0, 1'b1, 10, -1, '0);
    slot(1, LZB ? 7'h7F : 7'h01, LZB, 1'b1, 10, -1, '0);
    slot(2, LZB ? 7'h7F : 7'h01, LZB, 1'b1, 10, -1, '0);
    slot(3, LZB ? 7'h7F : 7'h01, LZB, 1'b1, 10, -1, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
